// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the VRAM write arbiter.
package vram_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 18;
  localparam int unsigned DEF_DATA_WIDTH   = 2;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned STARVE_W         = 8;

  typedef enum logic {
    ST_GAME  = 1'b0,
    ST_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no read bypass, so a push is visible one cycle later.
module sync_fifo #(
  parameter  int unsigned WIDTH = 20,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == LVL_W'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;

endmodule

// File: rtl/vram_write_arbiter.sv
// Merges game-state writes (priority) and buffered mouse-draw writes onto one VRAM write port,
// forcing one draw write after STARVE_LIMIT consecutive game grants while draws wait.
module vram_write_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          gst_req_i,
  input  logic [ADDR_WIDTH-1:0]         gst_addr_i,
  input  logic [DATA_WIDTH-1:0]         gst_data_i,
  output logic                          gst_gnt_o,
  input  logic                          mpd_valid_i,
  input  logic [ADDR_WIDTH-1:0]         mpd_addr_i,
  input  logic [DATA_WIDTH-1:0]         mpd_data_i,
  output logic                          mpd_ready_o,
  output logic                          vram_wr_en_o,
  output logic [ADDR_WIDTH-1:0]         vram_wr_address_o,
  output logic [DATA_WIDTH-1:0]         vram_wr_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_push;

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                gnt;
  logic                pop;

  // Ready is held low during reset so nothing is accepted into a FIFO being cleared.
  assign mpd_ready_o = ~fifo_full & ~reset_i;
  assign fifo_push   = mpd_valid_i & mpd_ready_o;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push      (fifo_push),
    .push_data ({mpd_addr_i, mpd_data_i}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_GAME;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grant/pop decision and starvation tracking.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    gnt      = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_GAME: begin
        if (gst_req_i && !reset_i) begin
          gnt = 1'b1;
          if (fifo_empty) begin
            starve_d = '0;
          end else begin
            starve_d = starve_q + STARVE_W'(1);
            if (starve_d == STARVE_W'(STARVE_LIMIT)) state_d = ST_FORCE;
          end
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      ST_FORCE: begin
        pop      = ~fifo_empty;
        starve_d = '0;
        state_d  = ST_GAME;
      end
    endcase
  end

  // Registered write port; address and data hold when no write is issued.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vram_wr_en_o      <= 1'b0;
      vram_wr_address_o <= '0;
      vram_wr_data_o    <= '0;
    end else begin
      vram_wr_en_o <= gnt | pop;
      if (gnt) begin
        vram_wr_address_o <= gst_addr_i;
        vram_wr_data_o    <= gst_data_i;
      end else if (pop) begin
        {vram_wr_address_o, vram_wr_data_o} <= fifo_head;
      end
    end
  end

  assign gst_gnt_o    = gnt;
  assign fifo_level_o = fifo_level;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed scenarios plus random traffic, checked against a queue-based model of the arbiter rules.
module tb_vram_write_arbiter;

  localparam int unsigned AW    = 18;
  localparam int unsigned DW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          gst_req_i;
  logic [AW-1:0] gst_addr_i;
  logic [DW-1:0] gst_data_i;
  logic          gst_gnt_o;
  logic          mpd_valid_i;
  logic [AW-1:0] mpd_addr_i;
  logic [DW-1:0] mpd_data_i;
  logic          mpd_ready_o;
  logic          vram_wr_en_o;
  logic [AW-1:0] vram_wr_address_o;
  logic [DW-1:0] vram_wr_data_o;
  logic [LW-1:0] fifo_level_o;

  vram_write_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .gst_req_i         (gst_req_i),
    .gst_addr_i        (gst_addr_i),
    .gst_data_i        (gst_data_i),
    .gst_gnt_o         (gst_gnt_o),
    .mpd_valid_i       (mpd_valid_i),
    .mpd_addr_i        (mpd_addr_i),
    .mpd_data_i        (mpd_data_i),
    .mpd_ready_o       (mpd_ready_o),
    .vram_wr_en_o      (vram_wr_en_o),
    .vram_wr_address_o (vram_wr_address_o),
    .vram_wr_data_o    (vram_wr_data_o),
    .fifo_level_o      (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state: waiting draws, consecutive-grant count, pending forced draw.
  logic [AW+DW-1:0] mq[$];
  int               starve;
  bit               forcing;
  logic [AW-1:0]    last_addr;
  logic [DW-1:0]    last_data;
  logic [AW-1:0]    wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    starve    = 0;
    forcing   = 1'b0;
    last_addr = '0;
    last_data = '0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, check the registered write.
  task automatic cycle(input logic req, input logic [AW-1:0] ga, input logic [DW-1:0] gd,
                       input logic v, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       output bit acc, output bit granted);
    bit            exp_ready, exp_gnt, do_pop, exp_wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    gst_req_i   = req;
    gst_addr_i  = ga;
    gst_data_i  = gd;
    mpd_valid_i = v;
    mpd_addr_i  = ma;
    mpd_data_i  = md;
    #1;
    exp_ready = (mq.size() < DEPTH);
    exp_gnt   = !forcing && req;
    do_pop    = forcing || (!req && mq.size() != 0);
    exp_wr    = exp_gnt || do_pop;
    chk("gnt", 32'(gst_gnt_o), 32'(exp_gnt));
    chk("ready", 32'(mpd_ready_o), 32'(exp_ready));
    chk("level", 32'(fifo_level_o), 32'(mq.size()));
    if (exp_gnt)     {ea, ed} = {ga, gd};
    else if (do_pop) {ea, ed} = mq[0];
    else             {ea, ed} = {last_addr, last_data};
    acc     = v && exp_ready;
    granted = exp_gnt;
    if (forcing) begin
      forcing = 1'b0;
      starve  = 0;
    end else if (do_pop || mq.size() == 0) begin
      starve = 0;
    end else if (exp_gnt) begin
      starve++;
      if (starve == LIMIT) forcing = 1'b1;
    end
    if (do_pop) void'(mq.pop_front());
    if (acc) mq.push_back({ma, md});
    @(posedge clk_i);
    #1;
    chk("wr_en", 32'(vram_wr_en_o), 32'(exp_wr));
    chk("wr_addr", 32'(vram_wr_address_o), 32'(ea));
    chk("wr_data", 32'(vram_wr_data_o), 32'(ed));
    last_addr = ea;
    last_data = ed;
    if (vram_wr_en_o === 1'b1) wlog.push_back(vram_wr_address_o);
  endtask

  task automatic idle();
    bit a, g;
    cycle(1'b0, '0, '0, 1'b0, '0, '0, a, g);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && mq.size() != 0; n++) idle();
    chk("drain_level", 32'(fifo_level_o), 32'd0);
  endtask

  task automatic apply_reset();
    gst_req_i   = 1'b1;
    mpd_valid_i = 1'b1;
    reset_i     = 1'b1;
    #1;
    chk("rst_gnt", 32'(gst_gnt_o), 32'd0);
    chk("rst_ready", 32'(mpd_ready_o), 32'd0);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_wr_en", 32'(vram_wr_en_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_addr", 32'(vram_wr_address_o), 32'd0);
    chk("rst_data", 32'(vram_wr_data_o), 32'd0);
    chk("rst_hold_gnt", 32'(gst_gnt_o), 32'd0);
    gst_req_i   = 1'b0;
    mpd_valid_i = 1'b0;
    reset_i     = 1'b0;
    #1;
    chk("rst_release_ready", 32'(mpd_ready_o), 32'd1);
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            a, g;
    int            k, gi;
    logic [AW-1:0] draws[$];

    reset_i     = 1'b1;
    gst_req_i   = 1'b0;
    gst_addr_i  = '0;
    gst_data_i  = '0;
    mpd_valid_i = 1'b0;
    mpd_addr_i  = '0;
    mpd_data_i  = '0;
    model_clear();
    apply_reset();

    // Game-only write appears one cycle after its grant.
    cycle(1'b1, AW'('h00100), 2'b01, 1'b0, '0, '0, a, g);
    chk("game_gnt_seen", 32'(g), 32'd1);
    chk("game_addr", 32'(vram_wr_address_o), 32'h100);
    chk("game_data", 32'(vram_wr_data_o), 32'h1);
    idle();

    // Draw-only: three pushes drain in order.
    wlog.delete();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, AW'(5 + i), DW'(i), a, g);
    drain();
    chk("draw_count", 32'(wlog.size()), 32'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("draw_order", 32'(wlog[i]), 32'(5 + i));

    // Starvation: after the push, LIMIT game writes, then the forced draw, then games resume.
    cycle(1'b1, AW'('h1000), 2'd2, 1'b1, AW'('h2A), 2'd3, a, g);
    wlog.delete();
    gi = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, AW'('h1100 + gi), DW'(gi), 1'b0, '0, '0, a, g);
      if (g) gi++;
    end
    chk("starve_len", 32'(wlog.size()), 32'd12);
    if (wlog.size() >= 10) begin
      for (int i = 0; i < LIMIT; i++) chk("starve_game", 32'(wlog[i]), 32'('h1100 + i));
      chk("starve_forced", 32'(wlog[LIMIT]), 32'h2A);
      chk("starve_resume", 32'(wlog[LIMIT+1]), 32'h1108);
    end
    drain();

    // Full FIFO: fifth push is held while ready is low, then lands in order.
    wlog.delete();
    k  = 0;
    gi = 0;
    for (int t = 0; t < 40 && k < 5; t++) begin
      cycle(1'b1, AW'('h2000 + gi), '0, 1'b1, AW'('h30 + k), DW'(k), a, g);
      if (g) gi++;
      if (a) begin
        k++;
        if (k == 4) begin
          chk("full_ready_low", 32'(mpd_ready_o), 32'd0);
          chk("full_level", 32'(fifo_level_o), 32'd4);
        end
      end
    end
    chk("full_all_pushed", 32'(k), 32'd5);
    drain();
    draws.delete();
    foreach (wlog[i]) if (wlog[i] >= AW'('h30) && wlog[i] < AW'('h35)) draws.push_back(wlog[i]);
    chk("full_draw_count", 32'(draws.size()), 32'd5);
    for (int i = 0; i < 5 && i < draws.size(); i++) chk("full_draw_order", 32'(draws[i]), 32'('h30 + i));

    // Mid-operation reset discards buffered and registered writes.
    for (int i = 0; i < 3; i++) cycle(1'b1, AW'('h3000 + i), '0, 1'b1, AW'('h50 + i), '0, a, g);
    chk("pre_reset_level", 32'(fifo_level_o), 32'd3);
    apply_reset();
    chk("post_reset_level", 32'(fifo_level_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("post_reset_no_wr", 32'(vram_wr_en_o), 32'd0);
    end

    // Simultaneous push and pop at level 2.
    wlog.delete();
    cycle(1'b1, AW'('h4000), '0, 1'b1, AW'('h41), 2'd1, a, g);
    cycle(1'b1, AW'('h4001), '0, 1'b1, AW'('h42), 2'd2, a, g);
    chk("pp_level_before", 32'(fifo_level_o), 32'd2);
    cycle(1'b0, '0, '0, 1'b1, AW'('h43), 2'd3, a, g);
    chk("pp_level_after", 32'(fifo_level_o), 32'd2);
    drain();
    chk("pp_count", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      chk("pp_order0", 32'(wlog[2]), 32'h41);
      chk("pp_order1", 32'(wlog[3]), 32'h42);
      chk("pp_order2", 32'(wlog[4]), 32'h43);
    end

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom), a, g);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
